zap_wb_write_arbiter: RTL and testbench

Shares the register file's two write ports among three requesters: exception entry, pipeline retirement and coprocessor register writes. Exception entry and pipeline retirement are unbuffered. Coprocessor writes are held in a small FIFO and drained into idle or unused port slots. A starvation guard stalls the pipeline if coprocessor writes wait too long. Sits between the writeback control logic and the register file, and drives its write interface through registered outputs.

---
 rtl/zap_wb_write_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_zap_wb_write_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/zap_wb_write_arbiter.sv
// ----------------------------------------------------------------------------
// zap_wb_write_arbiter
//
// Shares the register file's two write ports among three sources:
//   * exception entry (R14 + SPSR), unbuffered, highest priority
//   * pipeline retirement (ALU result + optional load result), unbuffered
//   * coprocessor register writes, buffered in a small FIFO and drained into
//     idle cycles or into the unused second port of a retiring instruction
// A starvation guard requests a pipeline stall when queued coprocessor
// writes have gone undrained for too long.
//
// Ports:
//   i_clk, i_reset_n            clock, asynchronous active-low reset
//   i_exc_*                     exception entry write request (two ports)
//   i_pipe_*                    retiring instruction write request (two ports;
//                               port-2 index RAZ_INDEX means unused)
//   i_copro_valid/o_copro_ready coprocessor write handshake
//   i_copro_wa/i_copro_wd       coprocessor write index/data
//   o_wen, o_wa1/o_wd1,
//   o_wa2/o_wd2                 registered register-file write interface
//   o_stall_pipe                registered starvation stall request
//   o_copro_pending             FIFO holds at least one write
// ----------------------------------------------------------------------------
module zap_wb_write_arbiter #(
    parameter int PHY_REGS     = 46,
    parameter int RAZ_INDEX    = 0,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8,
    localparam int IW          = $clog2(PHY_REGS)
) (
    input  logic          i_clk,
    input  logic          i_reset_n,

    input  logic          i_exc_req,
    input  logic [IW-1:0] i_exc_wa1,
    input  logic [31:0]   i_exc_wd1,
    input  logic [IW-1:0] i_exc_wa2,
    input  logic [31:0]   i_exc_wd2,

    input  logic          i_pipe_valid,
    input  logic [IW-1:0] i_pipe_wa1,
    input  logic [31:0]   i_pipe_wd1,
    input  logic [IW-1:0] i_pipe_wa2,
    input  logic [31:0]   i_pipe_wd2,

    input  logic          i_copro_valid,
    output logic          o_copro_ready,
    input  logic [IW-1:0] i_copro_wa,
    input  logic [31:0]   i_copro_wd,

    output logic          o_wen,
    output logic [IW-1:0] o_wa1,
    output logic [31:0]   o_wd1,
    output logic [IW-1:0] o_wa2,
    output logic [31:0]   o_wd2,
    output logic          o_stall_pipe,
    output logic          o_copro_pending
);

    localparam int            PW      = $clog2(FIFO_DEPTH);
    localparam logic [IW-1:0] RAZ     = IW'(RAZ_INDEX);
    localparam logic [7:0]    LIMIT   = 8'(STARVE_LIMIT);
    localparam logic [PW:0]   PTR_ONE = (PW+1)'(1);

    typedef enum logic {
        ST_RUN,
        ST_STALL
    } state_t;

    // ------------------------------------------------------------------
    // Coprocessor write FIFO. Pointers carry one extra wrap bit so that
    // full and empty are distinguishable with all slots in use.
    // ------------------------------------------------------------------
    logic [IW-1:0] r_fifo_wa [FIFO_DEPTH];
    logic [31:0]   r_fifo_wd [FIFO_DEPTH];
    logic [PW:0]   r_wr_ptr;
    logic [PW:0]   r_rd_ptr;

    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic [IW-1:0] w_head_wa;
    logic [31:0]   w_head_wd;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                       (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
    assign w_push    = i_copro_valid && !w_full;
    assign w_head_wa = r_fifo_wa[r_rd_ptr[PW-1:0]];
    assign w_head_wd = r_fifo_wd[r_rd_ptr[PW-1:0]];

    assign o_copro_ready   = !w_full;
    assign o_copro_pending = !w_empty;

    // Storage needs no reset: only slots between the pointers are ever read.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo_wa[r_wr_ptr[PW-1:0]] <= i_copro_wa;
            r_fifo_wd[r_wr_ptr[PW-1:0]] <= i_copro_wd;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Grant selection
    // ------------------------------------------------------------------
    logic          w_wen;
    logic [IW-1:0] w_wa1;
    logic [31:0]   w_wd1;
    logic [IW-1:0] w_wa2;
    logic [31:0]   w_wd2;

    always_comb begin
        w_pop = 1'b0;
        w_wen = 1'b0;
        w_wa1 = RAZ;
        w_wd1 = '0;
        w_wa2 = RAZ;
        w_wd2 = '0;
        if (i_exc_req) begin
            // Exception entry owns both ports; any pipeline request this
            // cycle has been squashed upstream.
            w_wen = 1'b1;
            w_wa1 = i_exc_wa1;
            w_wd1 = i_exc_wd1;
            w_wa2 = i_exc_wa2;
            w_wd2 = i_exc_wd2;
        end else if (i_pipe_valid) begin
            w_wen = 1'b1;
            w_wa1 = i_pipe_wa1;
            w_wd1 = i_pipe_wd1;
            // Piggyback the FIFO head on the free second port, unless it
            // targets the same register as the (newer) ALU result: the
            // older coprocessor value must not land alongside it.
            if ((i_pipe_wa2 == RAZ) && !w_empty && (w_head_wa != i_pipe_wa1)) begin
                w_wa2 = w_head_wa;
                w_wd2 = w_head_wd;
                w_pop = 1'b1;
            end else if (i_pipe_wa2 != RAZ) begin
                w_wa2 = i_pipe_wa2;
                w_wd2 = i_pipe_wd2;
            end
        end else if (!w_empty) begin
            w_wen = 1'b1;
            w_wa1 = w_head_wa;
            w_wd1 = w_head_wd;
            w_pop = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_wen <= 1'b0;
            o_wa1 <= RAZ;
            o_wd1 <= '0;
            o_wa2 <= RAZ;
            o_wd2 <= '0;
        end else begin
            o_wen <= w_wen;
            o_wa1 <= w_wa1;
            o_wd1 <= w_wd1;
            o_wa2 <= w_wa2;
            o_wd2 <= w_wd2;
        end
    end

    // ------------------------------------------------------------------
    // Starvation counter: cycles the FIFO has been non-empty without a pop.
    // ------------------------------------------------------------------
    logic [7:0] r_starve_cnt;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_starve_cnt <= '0;
        end else if (w_pop || w_empty) begin
            r_starve_cnt <= '0;
        end else if (r_starve_cnt != LIMIT) begin
            r_starve_cnt <= r_starve_cnt + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Stall FSM with registered stall output.
    // ------------------------------------------------------------------
    state_t r_state;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= ST_RUN;
            o_stall_pipe <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    // A pop in the same cycle already relieves the FIFO, so
                    // stalling would only waste a pipeline cycle.
                    if ((r_starve_cnt == LIMIT) && !w_pop) begin
                        r_state      <= ST_STALL;
                        o_stall_pipe <= 1'b1;
                    end
                end
                ST_STALL: begin
                    if (w_pop || i_exc_req) begin
                        r_state      <= ST_RUN;
                        o_stall_pipe <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= ST_RUN;
                    o_stall_pipe <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zap_wb_write_arbiter.sv
module tb_zap_wb_write_arbiter;

    logic        clk;
    logic        rst_n;
    logic        exc_req;
    logic [5:0]  exc_wa1, exc_wa2;
    logic [31:0] exc_wd1, exc_wd2;
    logic        pipe_valid;
    logic [5:0]  pipe_wa1, pipe_wa2;
    logic [31:0] pipe_wd1, pipe_wd2;
    logic        copro_valid;
    logic        copro_ready;
    logic [5:0]  copro_wa;
    logic [31:0] copro_wd;
    logic        o_wen;
    logic [5:0]  o_wa1, o_wa2;
    logic [31:0] o_wd1, o_wd2;
    logic        stall_pipe;
    logic        copro_pending;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic        wen;
        logic [5:0]  wa1;
        logic [31:0] wd1;
        logic [5:0]  wa2;
        logic [31:0] wd2;
    } exp_t;

    exp_t exp_q[$];

    zap_wb_write_arbiter dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .i_exc_req      (exc_req),
        .i_exc_wa1      (exc_wa1),
        .i_exc_wd1      (exc_wd1),
        .i_exc_wa2      (exc_wa2),
        .i_exc_wd2      (exc_wd2),
        .i_pipe_valid   (pipe_valid),
        .i_pipe_wa1     (pipe_wa1),
        .i_pipe_wd1     (pipe_wd1),
        .i_pipe_wa2     (pipe_wa2),
        .i_pipe_wd2     (pipe_wd2),
        .i_copro_valid  (copro_valid),
        .o_copro_ready  (copro_ready),
        .i_copro_wa     (copro_wa),
        .i_copro_wd     (copro_wd),
        .o_wen          (o_wen),
        .o_wa1          (o_wa1),
        .o_wd1          (o_wd1),
        .o_wa2          (o_wa2),
        .o_wd2          (o_wd2),
        .o_stall_pipe   (stall_pipe),
        .o_copro_pending(copro_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        exc_req     = 1'b0; exc_wa1  = '0; exc_wd1  = '0; exc_wa2  = '0; exc_wd2  = '0;
        pipe_valid  = 1'b0; pipe_wa1 = '0; pipe_wd1 = '0; pipe_wa2 = '0; pipe_wd2 = '0;
        copro_valid = 1'b0; copro_wa = '0; copro_wd = '0;
    endtask

    task automatic pipe(input logic [5:0] wa1, input logic [31:0] wd1,
                        input logic [5:0] wa2, input logic [31:0] wd2);
        pipe_valid = 1'b1; pipe_wa1 = wa1; pipe_wd1 = wd1; pipe_wa2 = wa2; pipe_wd2 = wd2;
    endtask

    task automatic copro(input logic [5:0] wa, input logic [31:0] wd);
        copro_valid = 1'b1; copro_wa = wa; copro_wd = wd;
    endtask

    // Record the write expected on the outputs one cycle after the current stimulus.
    task automatic expect_wr(input string tag, input logic wen,
                             input logic [5:0] wa1, input logic [31:0] wd1,
                             input logic [5:0] wa2, input logic [31:0] wd2);
        exp_t e;
        e.tag = tag; e.wen = wen; e.wa1 = wa1; e.wd1 = wd1; e.wa2 = wa2; e.wd2 = wd2;
        exp_q.push_back(e);
    endtask

    // Advance one clock and compare the write outputs with the scoreboard head.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty: observed wen=%0b with no expected entry", o_wen);
        end else begin
            e = exp_q.pop_front();
            assert ({o_wen, o_wa1, o_wd1, o_wa2, o_wd2} === {e.wen, e.wa1, e.wd1, e.wa2, e.wd2})
            else begin
                failures++;
                $error("FAIL %s: observed wen=%0b wa1=%0d wd1=%h wa2=%0d wd2=%h expected wen=%0b wa1=%0d wd1=%h wa2=%0d wd2=%h",
                       e.tag, o_wen, o_wa1, o_wd1, o_wa2, o_wd2, e.wen, e.wa1, e.wd1, e.wa2, e.wd2);
            end
        end
        $display("txn %s: wen=%0b wa1=%0d wd1=%h wa2=%0d wd2=%h stall=%0b ready=%0b pending=%0b",
                 e.tag, o_wen, o_wa1, o_wd1, o_wa2, o_wd2, stall_pipe, copro_ready, copro_pending);
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        check_val("rst_wen",     32'(o_wen), 32'd0);
        check_val("rst_wa1",     32'(o_wa1), 32'd0);
        check_val("rst_wa2",     32'(o_wa2), 32'd0);
        check_val("rst_wd",      o_wd1 | o_wd2, 32'd0);
        check_val("rst_stall",   32'(stall_pipe), 32'd0);
        check_val("rst_ready",   32'(copro_ready), 32'd1);
        check_val("rst_pending", 32'(copro_pending), 32'd0);
        rst_n = 1'b1;

        // Coprocessor write alone: no bypass, appears two cycles after the push
        copro(6'd5, 32'hA5A5_0001);
        expect_wr("copro_push_idle", 1'b0, 6'd0, 32'h0, 6'd0, 32'h0);
        tick();
        idle();
        check_val("copro_pending_set", 32'(copro_pending), 32'd1);
        expect_wr("copro_alone", 1'b1, 6'd5, 32'hA5A5_0001, 6'd0, 32'h0);
        tick();
        check_val("copro_pending_clr", 32'(copro_pending), 32'd0);

        // Piggyback on the unused second port of a retiring instruction
        copro(6'd7, 32'h77);
        expect_wr("pig_push_idle", 1'b0, 6'd0, 32'h0, 6'd0, 32'h0);
        tick();
        idle();
        pipe(6'd3, 32'h33, 6'd0, 32'h0);
        expect_wr("piggyback", 1'b1, 6'd3, 32'h33, 6'd7, 32'h77);
        tick();
        idle();
        check_val("pig_fifo_empty", 32'(copro_pending), 32'd0);

        // Same-index conflict defers the FIFO head until the pipe is idle
        copro(6'd3, 32'hC3);
        expect_wr("conf_push_idle", 1'b0, 6'd0, 32'h0, 6'd0, 32'h0);
        tick();
        idle();
        pipe(6'd3, 32'h333, 6'd0, 32'h0);
        expect_wr("conflict_1", 1'b1, 6'd3, 32'h333, 6'd0, 32'h0);
        tick();
        check_val("conf_still_pending", 32'(copro_pending), 32'd1);
        pipe(6'd3, 32'h334, 6'd0, 32'h0);
        expect_wr("conflict_2", 1'b1, 6'd3, 32'h334, 6'd0, 32'h0);
        tick();
        idle();
        expect_wr("conflict_drain", 1'b1, 6'd3, 32'hC3, 6'd0, 32'h0);
        tick();

        // Exception beats pipe and FIFO; FIFO untouched
        copro(6'd9, 32'h99);
        expect_wr("exc_push_idle", 1'b0, 6'd0, 32'h0, 6'd0, 32'h0);
        tick();
        idle();
        exc_req = 1'b1; exc_wa1 = 6'd22; exc_wd1 = 32'h100; exc_wa2 = 6'd23; exc_wd2 = 32'h13;
        pipe(6'd4, 32'h44, 6'd0, 32'h0);
        expect_wr("exception", 1'b1, 6'd22, 32'h100, 6'd23, 32'h13);
        tick();
        idle();
        check_val("exc_fifo_kept", 32'(copro_pending), 32'd1);
        expect_wr("exc_drain", 1'b1, 6'd9, 32'h99, 6'd0, 32'h0);
        tick();

        // Starvation: pipe keeps both ports busy
        copro(6'd10, 32'h1010);
        expect_wr("starve_push_idle", 1'b0, 6'd0, 32'h0, 6'd0, 32'h0);
        tick();
        for (int i = 1; i <= 9; i++) begin
            pipe(6'd1, 32'(i), 6'd2, 32'h100 + 32'(i));
            copro(6'(10 + i), 32'h1010 + 32'(i));
            expect_wr($sformatf("starve_pipe_%0d", i), 1'b1, 6'd1, 32'(i), 6'd2, 32'h100 + 32'(i));
            tick();
            check_val($sformatf("starve_stall_%0d", i), 32'(stall_pipe), (i == 9) ? 32'd1 : 32'd0);
            check_val($sformatf("starve_ready_%0d", i), 32'(copro_ready), (i < 3) ? 32'd1 : 32'd0);
        end
        idle();
        pipe(6'd1, 32'd10, 6'd2, 32'h10A);
        expect_wr("stall_pipe_kept", 1'b1, 6'd1, 32'd10, 6'd2, 32'h10A);
        tick();
        check_val("stall_held", 32'(stall_pipe), 32'd1);
        idle();
        expect_wr("stall_drain_10", 1'b1, 6'd10, 32'h1010, 6'd0, 32'h0);
        tick();
        check_val("stall_cleared", 32'(stall_pipe), 32'd0);
        expect_wr("drain_11", 1'b1, 6'd11, 32'h1011, 6'd0, 32'h0);
        tick();
        expect_wr("drain_12", 1'b1, 6'd12, 32'h1012, 6'd0, 32'h0);
        tick();
        expect_wr("drain_13", 1'b1, 6'd13, 32'h1013, 6'd0, 32'h0);
        tick();
        expect_wr("drain_done", 1'b0, 6'd0, 32'h0, 6'd0, 32'h0);
        tick();
        check_val("drain_empty", 32'(copro_pending), 32'd0);

        // Reset asserted mid-burst
        copro(6'd20, 32'h2020);
        expect_wr("burst_push", 1'b0, 6'd0, 32'h0, 6'd0, 32'h0);
        tick();
        copro(6'd21, 32'h2121);
        pipe(6'd5, 32'h55, 6'd6, 32'h66);
        expect_wr("burst_pipe", 1'b1, 6'd5, 32'h55, 6'd6, 32'h66);
        tick();
        idle();
        #2 rst_n = 1'b0;
        #1;
        check_val("midrst_wen", 32'(o_wen), 32'd0);
        check_val("midrst_wa",  32'({o_wa1, o_wa2}), 32'd0);
        check_val("midrst_wd",  o_wd1 | o_wd2, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        check_val("midrst_ready",   32'(copro_ready), 32'd1);
        check_val("midrst_pending", 32'(copro_pending), 32'd0);
        expect_wr("post_rst_idle", 1'b0, 6'd0, 32'h0, 6'd0, 32'h0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
